program_loader: RTL and testbench

- Boot-time stage directly upstream of the single-cycle RISC-V core.
- Receives a byte stream from a host link (UART receiver or testbench) over a valid/ready handshake.
- Assembles little-endian 32-bit instruction words into a 256-word image that drives the core's instruction-memory input array.
- Holds the core in reset until a length-framed, checksummed load completes.

---
 rtl/loader_pkg.sv | 18 +
 rtl/byte_assembler.sv | 42 ++++
 rtl/program_loader.sv | 119 +++++++++++
 tb/tb_program_loader.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time program loader.
// Holds the load-sequence states and the image geometry.
package loader_pkg;

    localparam int LOADER_MEM_WORDS = 256;
    localparam int LOADER_LEN_BYTES = 2;

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        CSUM,
        DONE,
        ERROR
    } loader_state_e;

endpackage

// File: rtl/byte_assembler.sv
// Packs four byte transfers into one little-endian 32-bit word.
// word/word_strobe are valid combinationally on the lane-3 transfer cycle.
module byte_assembler (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        byte_en,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic        word_strobe
);

    logic [1:0]  lane_q, lane_d;
    // Only lanes 0..2 need storage; lane 3 is taken straight from the input.
    logic [23:0] asm_q, asm_d;

    always_comb begin
        lane_d = lane_q;
        asm_d  = asm_q;
        if (clr) begin
            lane_d = '0;
            asm_d  = '0;
        end else if (byte_en) begin
            lane_d = lane_q + 2'd1;
            asm_d  = {byte_data, asm_q[23:8]};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lane_q <= '0;
            asm_q  <= '0;
        end else begin
            lane_q <= lane_d;
            asm_q  <= asm_d;
        end
    end

    assign word        = {byte_data, asm_q};
    assign word_strobe = byte_en && !clr && (lane_q == 2'd3);

endmodule

// File: rtl/program_loader.sv
// Loads a length-framed, XOR-checksummed byte stream into the core's
// instruction image and releases the core reset once the image is good.
module program_loader
    import loader_pkg::*;
#(
    parameter int MEM_WORDS = LOADER_MEM_WORDS,
    parameter int CNT_W     = $clog2(MEM_WORDS) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             byte_valid,
    input  logic [7:0]       byte_data,
    output logic             byte_ready,
    output logic [31:0]      mem_image [MEM_WORDS],
    output logic             core_rst_n,
    output logic             done,
    output logic             error,
    output logic [CNT_W-1:0] words_loaded
);

    localparam int IDX_W = CNT_W - 1;

    loader_state_e    state_q, state_d;
    logic [15:0]      len_q, len_d;
    logic [CNT_W-1:0] wl_q, wl_d, wl_inc;
    logic [7:0]       csum_q, csum_d;
    logic [31:0]      mem_q [MEM_WORDS];
    logic [15:0]      len_full;
    logic             xfer, data_xfer, restart;
    logic [31:0]      asm_word;
    logic             asm_strobe;

    assign byte_ready = (state_q == LEN_LO) || (state_q == LEN_HI) ||
                        (state_q == DATA)   || (state_q == CSUM);
    assign xfer       = byte_valid && byte_ready;
    assign data_xfer  = byte_valid && (state_q == DATA);
    assign restart    = start && ((state_q == IDLE) || (state_q == DONE) ||
                                  (state_q == ERROR));
    assign wl_inc     = wl_q + 1'b1;
    assign len_full   = {byte_data, len_q[7:0]};

    byte_assembler u_asm (
        .clk         (clk),
        .rst         (rst),
        .clr         (restart),
        .byte_en     (data_xfer),
        .byte_data   (byte_data),
        .word        (asm_word),
        .word_strobe (asm_strobe)
    );

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        wl_d    = wl_q;
        csum_d  = csum_q;
        case (state_q)
            IDLE: if (start) state_d = LEN_LO;
            LEN_LO: if (xfer) begin
                len_d[7:0] = byte_data;
                state_d    = LEN_HI;
            end
            LEN_HI: if (xfer) begin
                len_d[15:8] = byte_data;
                // Full 16-bit compare: a high byte of 1 with MEM_WORDS=256 must still reject 257.
                if (len_full == 16'd0 || len_full > 16'(MEM_WORDS)) state_d = ERROR;
                else                                                  state_d = DATA;
            end
            DATA: if (xfer) begin
                csum_d = csum_q ^ byte_data;
                if (asm_strobe) begin
                    wl_d = wl_inc;
                    if (16'(wl_inc) == len_q) state_d = CSUM;
                end
            end
            CSUM: if (xfer) state_d = (byte_data == csum_q) ? DONE : ERROR;
            DONE, ERROR: ;
            default: state_d = IDLE;
        endcase
        if (restart) begin
            state_d = LEN_LO;
            len_d   = '0;
            wl_d    = '0;
            csum_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            len_q   <= '0;
            wl_q    <= '0;
            csum_q  <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            wl_q    <= wl_d;
            csum_q  <= csum_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < MEM_WORDS; i++) mem_q[i] <= '0;
        end else if (restart) begin
            for (int i = 0; i < MEM_WORDS; i++) mem_q[i] <= '0;
        end else if (asm_strobe) begin
            mem_q[wl_q[IDX_W-1:0]] <= asm_word;
        end
    end

    assign mem_image    = mem_q;
    assign done         = (state_q == DONE);
    assign error        = (state_q == ERROR);
    assign core_rst_n   = (state_q == DONE);
    assign words_loaded = wl_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: table-driven load sequences plus
// hand-written sequences for stalls, async reset, restart and full-length load.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic [31:0] mem_image [256];
    logic        core_rst_n;
    logic        done;
    logic        error;
    logic [8:0]  words_loaded;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       st;
        logic       vld;
        logic [7:0] dat;
        logic       rdy;
        logic       dn;
        logic       er;
        logic       crn;
        logic [8:0] wl;
    } vec_t;

    vec_t tbl_ok  [12];
    vec_t tbl_bad [12];

    program_loader dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .byte_valid   (byte_valid),
        .byte_data    (byte_data),
        .byte_ready   (byte_ready),
        .mem_image    (mem_image),
        .core_rst_n   (core_rst_n),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic st, input logic v, input logic [7:0] d,
                                input logic rdy, input logic dn, input logic er,
                                input logic crn, input logic [8:0] wl);
        vec_t r;
        r.st = st; r.vld = v; r.dat = d;
        r.rdy = rdy; r.dn = dn; r.er = er; r.crn = crn; r.wl = wl;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Drive inputs on the falling edge, let one rising edge happen, settle.
    task automatic cyc(input logic s, input logic v, input logic [7:0] d);
        @(negedge clk);
        start = s; byte_valid = v; byte_data = d;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_outs(input string name, input logic rdy, input logic dn,
                            input logic er, input logic crn, input logic [8:0] wl);
        chk(name, {19'd0, byte_ready, done, error, core_rst_n, words_loaded},
                  {19'd0, rdy, dn, er, crn, wl});
    endtask

    task automatic run_tbl(input vec_t t [12], input string tag);
        for (int i = 0; i < 12; i++) begin
            cyc(t[i].st, t[i].vld, t[i].dat);
            chk_outs($sformatf("%s[%0d]", tag, i), t[i].rdy, t[i].dn, t[i].er, t[i].crn, t[i].wl);
        end
    endtask

    initial begin
        logic [7:0]  s1 [11];
        logic        any_nz;
        logic        img_ok;
        logic [31:0] w;

        s1 = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h10, 8'h00, 8'h93, 8'h00, 8'h20, 8'h00, 8'hB0};

        tbl_ok[0]  = mk(1, 0, 8'h00, 1, 0, 0, 0, 9'd0);
        tbl_ok[1]  = mk(0, 1, 8'h02, 1, 0, 0, 0, 9'd0);
        tbl_ok[2]  = mk(0, 1, 8'h00, 1, 0, 0, 0, 9'd0);
        tbl_ok[3]  = mk(0, 1, 8'h13, 1, 0, 0, 0, 9'd0);
        tbl_ok[4]  = mk(0, 1, 8'h00, 1, 0, 0, 0, 9'd0);
        tbl_ok[5]  = mk(0, 1, 8'h10, 1, 0, 0, 0, 9'd0);
        tbl_ok[6]  = mk(0, 1, 8'h00, 1, 0, 0, 0, 9'd1);
        tbl_ok[7]  = mk(0, 1, 8'h93, 1, 0, 0, 0, 9'd1);
        tbl_ok[8]  = mk(0, 1, 8'h00, 1, 0, 0, 0, 9'd1);
        tbl_ok[9]  = mk(0, 1, 8'h20, 1, 0, 0, 0, 9'd1);
        tbl_ok[10] = mk(0, 1, 8'h00, 1, 0, 0, 0, 9'd2);
        tbl_ok[11] = mk(0, 1, 8'hB0, 0, 1, 0, 1, 9'd2);
        tbl_bad     = tbl_ok;
        tbl_bad[11] = mk(0, 1, 8'hB1, 0, 0, 1, 0, 9'd2);

        rst = 1'b0; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
        #12;
        chk_outs("reset_outs", 0, 0, 0, 0, 9'd0);
        chk("reset_mem0", mem_image[0], 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // 1: good load
        run_tbl(tbl_ok, "s1");
        chk("s1_mem0", mem_image[0], 32'h00100013);
        chk("s1_mem1", mem_image[1], 32'h00200093);
        chk("s1_mem2", mem_image[2], 32'h0);

        // 2: same stream, bad checksum (restart from DONE)
        run_tbl(tbl_bad, "s2");
        chk("s2_mem0", mem_image[0], 32'h00100013);
        chk("s2_mem1", mem_image[1], 32'h00200093);
        cyc(0, 1, 8'h55);
        chk_outs("s2_hold", 0, 0, 1, 0, 9'd2);

        // 3: zero length, then 257
        cyc(1, 0, 8'h00);
        chk_outs("s3_restart", 1, 0, 0, 0, 9'd0);
        chk("s3_mem0_clr", mem_image[0], 32'h0);
        cyc(0, 1, 8'h00);
        chk_outs("s3_len0_lo", 1, 0, 0, 0, 9'd0);
        cyc(0, 1, 8'h00);
        chk_outs("s3_len0_err", 0, 0, 1, 0, 9'd0);
        cyc(1, 0, 8'h00);
        cyc(0, 1, 8'h01);
        cyc(0, 1, 8'h01);
        chk_outs("s3_len257_err", 0, 0, 1, 0, 9'd0);
        any_nz = 1'b0;
        for (int i = 0; i < 256; i++) if (mem_image[i] != 32'h0) any_nz = 1'b1;
        chk("s3_mem_all0", {31'd0, any_nz}, 32'd0);

        // 4: valid only every third cycle, data held across the gap
        cyc(1, 0, 8'h00);
        for (int i = 0; i < 11; i++) begin
            cyc(0, 0, s1[i]);
            cyc(0, 0, s1[i]);
            if (i == 10) chk_outs("s4_pre_csum", 1, 0, 0, 0, 9'd2);
            cyc(0, 1, s1[i]);
            if (i == 5) chk_outs("s4_word0", 1, 0, 0, 0, 9'd1);
        end
        chk_outs("s4_done", 0, 1, 0, 1, 9'd2);
        chk("s4_mem0", mem_image[0], 32'h00100013);
        chk("s4_mem1", mem_image[1], 32'h00200093);
        chk("s4_mem2", mem_image[2], 32'h0);

        // 5: async reset mid-load after word 0
        cyc(1, 0, 8'h00);
        for (int i = 0; i < 6; i++) cyc(0, 1, s1[i]);
        chk_outs("s5_word0", 1, 0, 0, 0, 9'd1);
        chk("s5_mem0_pre", mem_image[0], 32'h00100013);
        @(negedge clk);
        byte_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk_outs("s5_async_outs", 0, 0, 0, 0, 9'd0);
        chk("s5_async_mem0", mem_image[0], 32'h0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 8'h93);
            chk_outs($sformatf("s5_ignore[%0d]", i), 0, 0, 0, 0, 9'd0);
        end
        chk("s5_mem0_post", mem_image[0], 32'h0);

        // 6: reach DONE, restart, then full 256-word load
        run_tbl(tbl_ok, "s6a");
        cyc(1, 0, 8'h00);
        chk_outs("s6_restart", 1, 0, 0, 0, 9'd0);
        chk("s6_mem0_clr", mem_image[0], 32'h0);
        chk("s6_mem1_clr", mem_image[1], 32'h0);
        cyc(0, 1, 8'h00);
        cyc(0, 1, 8'h01);
        chk_outs("s6_len256", 1, 0, 0, 0, 9'd0);
        for (int i = 0; i < 256; i++)
            for (int k = 0; k < 4; k++) cyc(0, 1, 8'(i));
        chk_outs("s6_pre_csum", 1, 0, 0, 0, 9'd256);
        // Each word is four copies of one byte, so the XOR over the image is 0.
        cyc(0, 1, 8'h00);
        chk_outs("s6_done", 0, 1, 0, 1, 9'd256);
        chk("s6_mem255", mem_image[255], 32'hFFFFFFFF);
        img_ok = 1'b1;
        for (int i = 0; i < 256; i++) begin
            w = 32'(i) * 32'h01010101;
            if (mem_image[i] !== w) img_ok = 1'b0;
        end
        chk("s6_image", {31'd0, img_ok}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
